gd_sweep_scheduler: RTL and testbench

//  Multi-start controller for the gradient-descent core (Top).
//  - Runs the core once per starting point (a,b,c,d), advancing each coordinate by a fixed step per run.
//  - Tracks the lowest z_min over all runs and reports it with the coordinates at the minimum.
//  - Owns the core's start_op and rst_n, and sequences start, done, clear and done-low between runs.

---
 rtl/gd_pkg.sv | 39 +++
 rtl/gd_best_tracker.sv | 36 +++
 rtl/gd_sweep_scheduler.sv | 156 +++++++++++++++
 tb/tb_gd_sweep_scheduler.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gd_pkg.sv
// Shared types for the gradient-descent sweep scheduler.
// Point bundle, FSM state encoding and point stepping helper.
package gd_pkg;

  localparam int Q24_8_W = 32;
  localparam int COORD_W = 8;
  localparam logic [Q24_8_W-1:0] Z_MAX = 32'h7FFF_FFFF;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t a;
    coord_t b;
    coord_t c;
    coord_t d;
  } point_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_CAPTURE,
    S_CLEAR,
    S_WAITLOW,
    S_DONE
  } state_t;

  // 8-bit two's-complement wrap on every coordinate
  function automatic point_t point_add(point_t p, coord_t s);
    point_t r;
    r.a = p.a + s;
    r.b = p.b + s;
    r.c = p.c + s;
    r.d = p.d + s;
    return r;
  endfunction

endpackage

// File: rtl/gd_best_tracker.sv
// Keeps the lowest signed z seen in a sweep and the point/run that made it.
// Strict less-than, so equal values keep the earlier run.
module gd_best_tracker
  import gd_pkg::*;
#(
  parameter int RUNS_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               cap,
  input  logic [Q24_8_W-1:0] z,
  input  point_t             pt,
  input  logic [RUNS_W-1:0]  idx,
  output logic [Q24_8_W-1:0] best_z,
  output point_t             best_pt,
  output logic [RUNS_W-1:0]  best_idx
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_z   <= Z_MAX;
      best_pt  <= '0;
      best_idx <= '0;
    end else if (clr) begin
      best_z   <= Z_MAX;
      best_pt  <= '0;
      best_idx <= '0;
    end else if (cap && ($signed(z) < $signed(best_z))) begin
      best_z   <= z;
      best_pt  <= pt;
      best_idx <= idx;
    end
  end

endmodule

// File: rtl/gd_sweep_scheduler.sv
// Multi-start sweep controller: runs the core once per start point,
// stepping every coordinate between runs and tracking the lowest z.
module gd_sweep_scheduler
  import gd_pkg::*;
#(
  parameter int RUNS_W         = 8,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CLR_CYCLES     = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sweep_start,
  input  logic [COORD_W-1:0] start_a,
  input  logic [COORD_W-1:0] start_b,
  input  logic [COORD_W-1:0] start_c,
  input  logic [COORD_W-1:0] start_d,
  input  logic [COORD_W-1:0] step,
  input  logic [RUNS_W-1:0]  num_runs,
  output logic               core_start,
  output logic               core_rst_n,
  output logic [COORD_W-1:0] core_a_init,
  output logic [COORD_W-1:0] core_b_init,
  output logic [COORD_W-1:0] core_c_init,
  output logic [COORD_W-1:0] core_d_init,
  input  logic [Q24_8_W-1:0] core_z_min,
  input  logic [COORD_W-1:0] core_a_min,
  input  logic [COORD_W-1:0] core_b_min,
  input  logic [COORD_W-1:0] core_c_min,
  input  logic [COORD_W-1:0] core_d_min,
  input  logic               core_done,
  output logic [Q24_8_W-1:0] best_z,
  output logic [COORD_W-1:0] best_a,
  output logic [COORD_W-1:0] best_b,
  output logic [COORD_W-1:0] best_c,
  output logic [COORD_W-1:0] best_d,
  output logic [RUNS_W-1:0]  best_idx,
  output logic [RUNS_W-1:0]  run_idx,
  output logic               busy,
  output logic               sweep_done,
  output logic               timeout_err
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CLR_W = $clog2(CLR_CYCLES + 1);

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q;
  logic [CLR_W-1:0]   clr_q;
  logic [RUNS_W-1:0]  last_q;
  coord_t             step_q;
  point_t             pt_q, init_q, min_pt, best_pt;
  logic               accept, expire, cap, advance;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    expire  = 1'b0;
    cap     = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      S_IDLE: if (sweep_start) begin
        accept  = 1'b1;
        state_d = S_LOAD;
      end
      S_LOAD:  state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (core_done) begin
          state_d = S_CAPTURE;
        end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          expire  = 1'b1;
          state_d = S_CLEAR;
        end
      end
      S_CAPTURE: begin
        cap     = 1'b1;
        state_d = S_CLEAR;
      end
      S_CLEAR: if (clr_q == CLR_W'(CLR_CYCLES - 1)) state_d = S_WAITLOW;
      S_WAITLOW: if (!core_done) begin
        if (run_idx == last_q) begin
          state_d = S_DONE;
        end else begin
          advance = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      clr_q       <= '0;
      run_idx     <= '0;
      last_q      <= '0;
      step_q      <= '0;
      pt_q        <= '0;
      init_q      <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= (state_q == S_WAIT) ? timer_q + 1'b1 : '0;
      clr_q   <= (state_q == S_CLEAR) ? clr_q + 1'b1 : '0;
      if (accept) begin
        run_idx     <= '0;
        last_q      <= (num_runs == '0) ? '0 : num_runs - 1'b1;
        step_q      <= step;
        pt_q        <= '{a: start_a, b: start_b, c: start_c, d: start_d};
        timeout_err <= 1'b0;
      end
      if (advance) begin
        run_idx <= run_idx + 1'b1;
        pt_q    <= point_add(pt_q, step_q);
      end
      if (state_q == S_LOAD) init_q <= pt_q;
      if (expire) timeout_err <= 1'b1;
    end
  end

  // Outputs decode straight from the registered state
  assign core_start = (state_q == S_WAIT) || (state_q == S_CAPTURE);
  assign core_rst_n = (state_q == S_START) || core_start;
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign sweep_done = (state_q == S_DONE);

  assign core_a_init = init_q.a;
  assign core_b_init = init_q.b;
  assign core_c_init = init_q.c;
  assign core_d_init = init_q.d;

  assign min_pt = '{a: core_a_min, b: core_b_min,
                    c: core_c_min, d: core_d_min};

  gd_best_tracker #(.RUNS_W(RUNS_W)) u_best (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (accept),
    .cap      (cap),
    .z        (core_z_min),
    .pt       (min_pt),
    .idx      (run_idx),
    .best_z   (best_z),
    .best_pt  (best_pt),
    .best_idx (best_idx)
  );

  assign best_a = best_pt.a;
  assign best_b = best_pt.b;
  assign best_c = best_pt.c;
  assign best_d = best_pt.d;

endmodule

// File: tb/tb_gd_sweep_scheduler.sv
// Bench for gd_sweep_scheduler: stub core with per-run delay and z,
// expected results computed from the sweep rules.
module tb_gd_sweep_scheduler;

  localparam int TMO = 16;
  localparam int CLR = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sweep_start = 1'b0;
  logic [7:0]  start_a = '0, start_b = '0, start_c = '0, start_d = '0;
  logic [7:0]  step = '0, num_runs = '0;
  logic        core_start, core_rst_n, core_done;
  logic [7:0]  core_a_init, core_b_init, core_c_init, core_d_init;
  logic [31:0] core_z_min;
  logic [7:0]  core_a_min, core_b_min, core_c_min, core_d_min;
  logic [31:0] best_z;
  logic [7:0]  best_a, best_b, best_c, best_d, best_idx, run_idx;
  logic        busy, sweep_done, timeout_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gd_sweep_scheduler #(
    .RUNS_W(8), .TIMEOUT_CYCLES(TMO), .CLR_CYCLES(CLR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sweep_start(sweep_start),
    .start_a(start_a), .start_b(start_b), .start_c(start_c),
    .start_d(start_d), .step(step), .num_runs(num_runs),
    .core_start(core_start), .core_rst_n(core_rst_n),
    .core_a_init(core_a_init), .core_b_init(core_b_init),
    .core_c_init(core_c_init), .core_d_init(core_d_init),
    .core_z_min(core_z_min), .core_a_min(core_a_min),
    .core_b_min(core_b_min), .core_c_min(core_c_min),
    .core_d_min(core_d_min), .core_done(core_done),
    .best_z(best_z), .best_a(best_a), .best_b(best_b),
    .best_c(best_c), .best_d(best_d), .best_idx(best_idx),
    .run_idx(run_idx), .busy(busy), .sweep_done(sweep_done),
    .timeout_err(timeout_err)
  );

  // Stub core: done rises after dly[run] cycles of start (0 = never)
  int          dly[16];
  logic [31:0] zv[16];
  int          runs_seen = 0;
  int          cur;
  int          scnt = 0;
  logic        sdone = 1'b0;

  always_comb cur = (runs_seen == 0) ? 0 :
                    ((runs_seen > 16) ? 15 : runs_seen - 1);

  assign core_done  = sdone;
  assign core_z_min = zv[cur];
  assign core_a_min = core_a_init ^ 8'h5A;
  assign core_b_min = core_b_init ^ 8'hA5;
  assign core_c_min = core_c_init + 8'd1;
  assign core_d_min = core_d_init;

  always @(posedge clk) begin
    if (!core_rst_n) begin
      scnt  <= 0;
      sdone <= 1'b0;
    end else if (core_start) begin
      scnt <= scnt + 1;
      if (dly[cur] != 0 && scnt + 1 == dly[cur]) sdone <= 1'b1;
    end
  end

  // Monitor: per-run init points, start-high length, rst falls, done pulses
  logic       mon_clr = 1'b0;
  logic       prev_start = 1'b0, prev_rst = 1'b0;
  logic [7:0] oa[16], ob[16], oc[16], od[16];
  int         hi_cnt[16];
  int         rst_falls = 0, done_pulses = 0;

  always @(negedge clk) begin
    prev_start <= core_start;
    prev_rst   <= core_rst_n;
    if (mon_clr) begin
      runs_seen   <= 0;
      rst_falls   <= 0;
      done_pulses <= 0;
    end else begin
      if (core_start && !prev_start) begin
        if (runs_seen < 16) begin
          oa[runs_seen]     <= core_a_init;
          ob[runs_seen]     <= core_b_init;
          oc[runs_seen]     <= core_c_init;
          od[runs_seen]     <= core_d_init;
          hi_cnt[runs_seen] <= 1;
        end
        runs_seen <= runs_seen + 1;
      end else if (core_start && runs_seen > 0 && runs_seen <= 16) begin
        hi_cnt[runs_seen-1] <= hi_cnt[runs_seen-1] + 1;
      end
      if (!core_rst_n && prev_rst) rst_falls <= rst_falls + 1;
      if (sweep_done) done_pulses <= done_pulses + 1;
    end
  end

  task automatic run_sweep(input logic [7:0] sa, input logic [7:0] sb,
                           input logic [7:0] sc, input logic [7:0] sd,
                           input logic [7:0] st, input logic [7:0] nr,
                           input bit poke);
    int          neff;
    logic [31:0] ez;
    logic [7:0]  ea, eb, ec, ed, eidx, pa, pb, pc, pd;
    bit          eto;
    bit          seen;
    neff = (nr == 0) ? 1 : int'(nr);
    ez = 32'h7FFF_FFFF;
    {ea, eb, ec, ed, eidx} = '0;
    eto = 1'b0;
    for (int r = 0; r < neff; r++) begin
      pa = sa + 8'(r) * st;
      pb = sb + 8'(r) * st;
      pc = sc + 8'(r) * st;
      pd = sd + 8'(r) * st;
      if (dly[r] == 0) eto = 1'b1;
      else if ($signed(zv[r]) < $signed(ez)) begin
        ez = zv[r];
        ea = pa ^ 8'h5A;
        eb = pb ^ 8'hA5;
        ec = pc + 8'd1;
        ed = pd;
        eidx = 8'(r);
      end
    end

    @(posedge clk); mon_clr = 1'b1;
    @(posedge clk); mon_clr = 1'b0;
    @(negedge clk);
    {start_a, start_b, start_c, start_d} = {sa, sb, sc, sd};
    step = st;
    num_runs = nr;
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    {start_a, start_b, start_c, start_d, step} = 40'($urandom);
    num_runs = 8'($urandom);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL busy_accept got=%b want=1", busy);
    end
    @(negedge clk);
    n_cmp++;
    if ({core_start, core_rst_n} !== 2'b01) begin
      n_bad++;
      $display("FAIL latency1 start,rst_n got=%b want=01",
               {core_start, core_rst_n});
    end
    @(negedge clk);
    n_cmp++;
    if (core_start !== 1'b1) begin
      n_bad++; $display("FAIL latency2 core_start got=%b want=1", core_start);
    end
    if (poke) begin
      repeat (3) @(negedge clk);
      sweep_start = 1'b1;
      num_runs = 8'($urandom_range(2, 9));
      @(negedge clk);
      sweep_start = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      if (sweep_done === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    n_cmp++;
    if (!seen) begin
      n_bad++; $display("FAIL sweep_timeout got=no_done want=done");
    end else begin
      n_cmp++;
      if (busy !== 1'b0) begin
        n_bad++; $display("FAIL busy_in_done got=%b want=0", busy);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (sweep_done !== 1'b0) begin
      n_bad++; $display("FAIL done_pulse_width got=%b want=0", sweep_done);
    end
    repeat (2) @(negedge clk);

    n_cmp++;
    if (best_z !== ez || best_idx !== eidx) begin
      n_bad++;
      $display("FAIL best_z/idx got=%h/%0d want=%h/%0d",
               best_z, best_idx, ez, eidx);
    end
    n_cmp++;
    if ({best_a, best_b, best_c, best_d} !== {ea, eb, ec, ed}) begin
      n_bad++;
      $display("FAIL best_pt got=%h want=%h",
               {best_a, best_b, best_c, best_d}, {ea, eb, ec, ed});
    end
    n_cmp++;
    if (timeout_err !== eto) begin
      n_bad++; $display("FAIL timeout_err got=%b want=%b", timeout_err, eto);
    end
    n_cmp++;
    if (runs_seen != neff || rst_falls != neff || done_pulses != 1) begin
      n_bad++;
      $display("FAIL run_counts runs/rstfalls/dones got=%0d/%0d/%0d want=%0d/%0d/1",
               runs_seen, rst_falls, done_pulses, neff, neff);
    end
    for (int r = 0; r < neff && r < runs_seen && r < 16; r++) begin
      pa = sa + 8'(r) * st;
      pb = sb + 8'(r) * st;
      pc = sc + 8'(r) * st;
      pd = sd + 8'(r) * st;
      n_cmp++;
      if ({oa[r], ob[r], oc[r], od[r]} !== {pa, pb, pc, pd}) begin
        n_bad++;
        $display("FAIL init_run%0d got=%h want=%h", r,
                 {oa[r], ob[r], oc[r], od[r]}, {pa, pb, pc, pd});
      end
      n_cmp++;
      if (hi_cnt[r] != ((dly[r] == 0) ? TMO : dly[r] + 2)) begin
        n_bad++;
        $display("FAIL start_len_run%0d got=%0d want=%0d", r, hi_cnt[r],
                 (dly[r] == 0) ? TMO : dly[r] + 2);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({core_start, core_rst_n, busy, sweep_done, timeout_err} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl got=%b want=00000",
               {core_start, core_rst_n, busy, sweep_done, timeout_err});
    end
    n_cmp++;
    if (best_z !== 32'h7FFF_FFFF || {best_a, best_b, best_c, best_d,
        best_idx, run_idx} !== 48'h0) begin
      n_bad++;
      $display("FAIL reset_best got=%h/%h want=7fffffff/0", best_z,
               {best_a, best_b, best_c, best_d, best_idx, run_idx});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    dly[0] = 10; zv[0] = 32'h100;
    run_sweep(8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'd1, 1'b0);
  endtask

  task automatic test_multi_tie();
    zv[0] = 32'h300; zv[1] = 32'h080; zv[2] = 32'h080; zv[3] = 32'h200;
    for (int r = 0; r < 4; r++) dly[r] = $urandom_range(1, 12);
    run_sweep(8'h00, 8'h10, 8'hF0, 8'h40, 8'h01, 8'd4, 1'b0);
    n_cmp++;
    if (best_idx !== 8'd1) begin
      n_bad++; $display("FAIL tie_earliest got=%0d want=1", best_idx);
    end
  endtask

  task automatic test_signed();
    dly[0] = 4; zv[0] = 32'h10;
    dly[1] = 7; zv[1] = 32'hFFFF_FF00;
    run_sweep(8'h05, 8'h06, 8'h07, 8'h08, 8'hFE, 8'd2, 1'b0);
    n_cmp++;
    if (best_z !== 32'hFFFF_FF00) begin
      n_bad++; $display("FAIL signed_min got=%h want=ffffff00", best_z);
    end
  endtask

  task automatic test_wrap();
    dly[0] = 3; zv[0] = 32'h20;
    dly[1] = 5; zv[1] = 32'h30;
    run_sweep(8'h7F, 8'h00, 8'hFF, 8'h80, 8'h01, 8'd2, 1'b0);
    n_cmp++;
    if (oa[1] !== 8'h80) begin
      n_bad++; $display("FAIL wrap_a got=%h want=80", oa[1]);
    end
  endtask

  task automatic test_timeout();
    dly[0] = 0; zv[0] = 32'h8000_0000;
    dly[1] = 5; zv[1] = 32'h40;
    run_sweep(8'h01, 8'h02, 8'h03, 8'h04, 8'h01, 8'd2, 1'b0);
    n_cmp++;
    if (timeout_err !== 1'b1 || best_z !== 32'h40 || best_idx !== 8'd1) begin
      n_bad++;
      $display("FAIL timeout_case got=%b/%h/%0d want=1/00000040/1",
               timeout_err, best_z, best_idx);
    end
  endtask

  task automatic test_busy_ignore();
    dly[0] = 6; zv[0] = 32'h77;
    dly[1] = 2; zv[1] = 32'h66;
    run_sweep(8'h11, 8'h22, 8'h33, 8'h44, 8'h03, 8'd2, 1'b1);
  endtask

  task automatic test_async_reset();
    bit hit;
    dly[0] = 3;  zv[0] = 32'h50;
    dly[1] = 0;  zv[1] = 32'h10;
    dly[2] = 12; zv[2] = 32'h20;
    @(posedge clk); mon_clr = 1'b1;
    @(posedge clk); mon_clr = 1'b0;
    @(negedge clk);
    {start_a, start_b, start_c, start_d, step} = {8'h09, 8'h08, 8'h07, 8'h06, 8'h02};
    num_runs = 8'd3;
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk);
      if (runs_seen == 3) hit = 1'b1;
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (!hit || timeout_err !== 1'b1 || best_z !== 32'h50 || core_start !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset got=%b/%b/%h/%b want=1/1/00000050/1",
               hit, timeout_err, best_z, core_start);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({core_start, core_rst_n, busy, sweep_done, timeout_err} !== 5'b0 ||
        {core_a_init, core_b_init, core_c_init, core_d_init} !== 32'h0) begin
      n_bad++;
      $display("FAIL async_reset_ctrl got=%b/%h want=00000/0",
               {core_start, core_rst_n, busy, sweep_done, timeout_err},
               {core_a_init, core_b_init, core_c_init, core_d_init});
    end
    n_cmp++;
    if (best_z !== 32'h7FFF_FFFF || {best_a, best_b, best_c, best_d,
        best_idx, run_idx} !== 48'h0) begin
      n_bad++;
      $display("FAIL async_reset_best got=%h/%h want=7fffffff/0", best_z,
               {best_a, best_b, best_c, best_d, best_idx, run_idx});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL post_reset_idle got=%b want=0", busy);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      for (int r = 0; r < 16; r++) begin
        dly[r] = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
        zv[r]  = ($urandom_range(0, 2) == 0) ? 32'h80 : $urandom;
      end
      run_sweep(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                8'($urandom), 8'($urandom_range(0, 6)), 1'b0);
    end
  endtask

  initial begin
    for (int r = 0; r < 16; r++) begin
      dly[r] = 1;
      zv[r] = '0;
    end
    test_reset();
    test_single();
    test_multi_tie();
    test_signed();
    test_wrap();
    test_timeout();
    test_busy_ignore();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
